// File: rtl/gcd_binary_w.sv
// Binary (Stein) GCD engine: shifts plus a single subtractor, at most 2*WIDTH+1 RUN cycles.
// Start restarts from any state; a completion updates result/cycles and pulses done once.
module gcd_binary_w #(
  parameter  int WIDTH = 16,
  localparam int KW    = $clog2(WIDTH + 1),
  localparam int CW    = $clog2(2 * WIDTH + 2)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             result_ready,
  output logic             busy,
  output logic             done,
  output logic [CW-1:0]    cycles
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] x, y, x_n, y_n, result_n;
  logic [WIDTH-1:0] diff_xy, diff_yx;
  logic [KW-1:0]    k, k_n;
  logic [CW-1:0]    cnt, cnt_n, cycles_n;
  logic             done_n;

  // Only the difference of the larger minus the smaller operand is ever used.
  assign diff_xy = x - y;
  assign diff_yx = y - x;

  always_comb begin
    state_n  = state;
    x_n      = x;
    y_n      = y;
    k_n      = k;
    cnt_n    = cnt;
    result_n = result;
    cycles_n = cycles;
    done_n   = 1'b0;
    if (start) begin
      x_n     = a;
      y_n     = b;
      k_n     = '0;
      cnt_n   = CW'(1);
      state_n = RUN;
    end else if (state == RUN) begin
      if (x == '0 || y == '0) begin
        // gcd(0, n) = n; restore the common power of two
        result_n = (x == '0) ? (y << k) : (x << k);
        cycles_n = cnt;
        done_n   = 1'b1;
        state_n  = IDLE;
      end else begin
        cnt_n = cnt + CW'(1);
        unique case ({x[0], y[0]})
          2'b00: begin
            x_n = x >> 1;
            y_n = y >> 1;
            k_n = k + KW'(1);
          end
          2'b01: x_n = x >> 1;
          2'b10: y_n = y >> 1;
          default: begin
            if (x >= y) x_n = diff_xy >> 1;
            else        y_n = diff_yx >> 1;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      x      <= '0;
      y      <= '0;
      k      <= '0;
      cnt    <= '0;
      result <= '0;
      cycles <= '0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      x      <= x_n;
      y      <= y_n;
      k      <= k_n;
      cnt    <= cnt_n;
      result <= result_n;
      cycles <= cycles_n;
      done   <= done_n;
    end
  end

  assign busy         = (state == RUN);
  assign result_ready = (state == IDLE) & ~start;

endmodule

// File: tb/tb_gcd_binary_w.sv
// Scoreboard bench for gcd_binary_w: a 16-bit instance for directed jobs and an
// 8-bit instance for a broad operand sweep against a Euclid reference.
module tb_gcd_binary_w;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        s16, rr16, busy16, done16;
  logic [15:0] a16, b16, r16;
  logic [5:0]  cyc16;
  logic        s8, rr8, busy8, done8;
  logic [7:0]  a8, b8, r8;
  logic [4:0]  cyc8;

  gcd_binary_w #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .start(s16), .a(a16), .b(b16), .result(r16),
    .result_ready(rr16), .busy(busy16), .done(done16), .cycles(cyc16));

  gcd_binary_w #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(s8), .a(a8), .b(b8), .result(r8),
    .result_ready(rr8), .busy(busy8), .done(done8), .cycles(cyc8));

  typedef struct {int g; int c;} exp_t;  // c == 0: only the 2W+1 bound is checked
  exp_t q16[$], q8[$];

  int n_cmp = 0, n_err = 0;
  int dn16 = 0, dn8 = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ref_gcd(input int av, input int bv);
    int t;
    while (bv != 0) begin
      t = av % bv;
      av = bv;
      bv = t;
    end
    return av;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst && done16) begin
      dn16++;
      if (q16.size() == 0) chk("done16_unexpected", 1, 0);
      else begin
        e = q16.pop_front();
        chk("result16", r16, e.g);
        chk("cycles16", cyc16, e.c);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && done8) begin
      dn8++;
      if (q8.size() == 0) chk("done8_unexpected", 1, 0);
      else begin
        e = q8.pop_front();
        chk("result8", r8, e.g);
        if (e.c == 0) chk("cycles8_bound", 32'(cyc8 <= 5'd17), 1);
        else          chk("cycles8", cyc8, e.c);
      end
    end
  end

  // Called at the negedge right after the last start edge; counts RUN cycles.
  task automatic wait16(input int ec, input int d0);
    int n = 0;
    while (busy16 && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("busy_cycles16", n, ec);
    @(negedge clk);
    chk("done_count16", dn16 - d0, 1);
    chk("rr16", rr16, 1);
    chk("done_width16", done16, 0);
  endtask

  task automatic run16(input int av, input int bv, input int eg, input int ec);
    int d0 = dn16;
    q16.push_back('{eg, ec});
    @(negedge clk); s16 = 1'b1; a16 = 16'(av); b16 = 16'(bv);
    @(negedge clk); s16 = 1'b0;
    wait16(ec, d0);
  endtask

  task automatic run8(input int av, input int bv, input int ec);
    int d0 = dn8;
    int n  = 0;
    q8.push_back('{ref_gcd(av, bv), ec});
    @(negedge clk); s8 = 1'b1; a8 = 8'(av); b8 = 8'(bv);
    @(negedge clk); s8 = 1'b0;
    while (busy8 && n < 40) begin
      n++;
      @(negedge clk);
    end
    @(negedge clk);
    chk("done_count8", dn8 - d0, 1);
  endtask

  initial begin
    int d0, prev, jobs8;
    int bl[10] = '{0, 1, 2, 3, 6, 17, 64, 128, 200, 255};
    rst = 1'b1; s16 = 1'b0; a16 = '0; b16 = '0; s8 = 1'b0; a8 = '0; b8 = '0;
    #1;
    chk("reset_rr", rr16, 1);
    chk("reset_result", r16, 0);
    chk("reset_cycles", cyc16, 0);
    chk("reset_busy", busy16, 0);
    chk("reset_done", done16, 0);
    @(negedge clk); rst = 1'b0;

    run16(48, 18, 6, 7);
    run16(0, 5, 5, 1);
    run16(7, 0, 7, 1);
    run16(0, 0, 0, 1);
    run16(1023, 1, 1, 11);
    run16(1023, 1023, 1023, 2);
    run16(65535, 1, 1, 17);

    // Restart on the 3rd RUN cycle: the first job must vanish silently.
    d0 = dn16; prev = r16;
    q16.push_back('{7, 5});
    @(negedge clk); s16 = 1'b1; a16 = 16'd48; b16 = 16'd18;
    @(negedge clk); s16 = 1'b0;
    @(negedge clk);
    @(negedge clk); s16 = 1'b1; a16 = 16'd35; b16 = 16'd14;
    @(negedge clk); s16 = 1'b0;
    chk("abort_result_held", r16, prev);
    wait16(5, d0);

    // Reset during the 4th RUN cycle.
    d0 = dn16;
    @(negedge clk); s16 = 1'b1; a16 = 16'd48; b16 = 16'd18;
    @(negedge clk); s16 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_result", r16, 0);
    chk("rst_cycles", cyc16, 0);
    chk("rst_busy", busy16, 0);
    @(negedge clk); rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("rst_no_done", dn16 - d0, 0);
    run16(12, 8, 4, 6);

    // start held for several edges: operands reload, result_ready stays low.
    d0 = dn16;
    q16.push_back('{4, 6});
    @(negedge clk); s16 = 1'b1; a16 = 16'd100; b16 = 16'd3;
    @(negedge clk); chk("hold_rr0", rr16, 0); a16 = 16'd9; b16 = 16'd27;
    @(negedge clk); chk("hold_rr1", rr16, 0); a16 = 16'd12; b16 = 16'd8;
    @(negedge clk); chk("hold_rr2", rr16, 0); s16 = 1'b0;
    chk("hold_rr3", rr16, 0);
    wait16(6, d0);

    // 8-bit: boundary jobs, then a sweep of every a against a set of b values.
    run8(255, 1, 9);
    run8(255, 255, 2);
    run8(0, 0, 1);
    run8(128, 0, 1);
    jobs8 = 4;
    for (int i = 0; i < 256; i++)
      for (int j = 0; j < 10; j++) begin
        run8(i, bl[j], 0);
        jobs8++;
      end
    for (int i = 0; i < 300; i++) begin
      run8(int'($urandom_range(255)), int'($urandom_range(255)), 0);
      jobs8++;
    end
    chk("jobs8_done", dn8, jobs8);
    chk("q8_empty", q8.size(), 0);
    chk("q16_empty", q16.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
